branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor: a bimodal table of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB). Fetch looks up each PC combinationally and gets a taken/target prediction. The execute stage closes the loop by returning each resolved B-type outcome (the branch-taken result and target), which trains the tables one cycle later.

---
 rtl/cpu_consts.sv | 35 +++
 rtl/branch_predictor_btb.sv | 65 ++++++
 rtl/branch_predictor.sv | 117 +++++++++++
 tb/tb_branch_predictor.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cpu_consts.sv
// ---------------------------------------------------------------------------
// cpu_consts
// Shared constants and types for the fetch-stage branch predictor.
//   bp_ctr_t      : 2-bit saturating counter encoding (SNT/WNT/WT/ST)
//   BP_CTR_RESET  : value every counter takes on reset (weak not-taken)
//   bpCtrNext     : saturating increment/decrement of a counter
// Optional feature macro used by the predictor: BP_GSHARE_EN
// ---------------------------------------------------------------------------
package cpu_consts;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t BP_CTR_RESET = WNT;

    // Move a counter one step toward the observed outcome, saturating at
    // the strong states so a single surprise cannot flip a strong bias.
    function automatic bp_ctr_t bpCtrNext(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t result;
        result = ctr;
        unique case (ctr)
            SNT: result = taken ? WNT : SNT;
            WNT: result = taken ? WT  : SNT;
            WT:  result = taken ? ST  : WNT;
            ST:  result = taken ? ST  : WT;
            default: result = ctr;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// ---------------------------------------------------------------------------
// bp_btb
// Direct-mapped branch target buffer: valid/tag/target array with one
// combinational lookup port and one synchronous write port.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (clears valids)
//   rd_pc_i          : lookup PC
//   rd_hit_o         : entry valid and tag matches
//   rd_target_o      : stored target on a hit, 0 otherwise
//   wr_en_i          : write strobe (taken branch resolved)
//   wr_pc_i          : PC of the branch being written
//   wr_target_i      : target to store
// ---------------------------------------------------------------------------
module bp_btb #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] rd_pc_i,
    output logic        rd_hit_o,
    output logic [63:0] rd_target_o,
    input  logic        wr_en_i,
    input  logic [63:0] wr_pc_i,
    input  logic [63:0] wr_target_i
);

    localparam int JB = $clog2(ENTRIES);
    localparam int TW = 64 - JB - 2;

    logic          valid_q  [ENTRIES];
    logic [TW-1:0] tag_q    [ENTRIES];
    logic [63:0]   target_q [ENTRIES];

    logic [JB-1:0] rdIdx;
    logic [JB-1:0] wrIdx;
    logic          unusedPcBits;

    assign rdIdx = rd_pc_i[JB+1:2];
    assign wrIdx = wr_pc_i[JB+1:2];

    // Instruction alignment bits never take part in indexing or tagging.
    assign unusedPcBits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

    // Lookup: a hit needs both a valid entry and a full upper-PC tag match,
    // so PCs that only share index bits do not alias into each other.
    always_comb begin
        rd_hit_o    = valid_q[rdIdx] && (tag_q[rdIdx] == rd_pc_i[63:JB+2]);
        rd_target_o = rd_hit_o ? target_q[rdIdx] : 64'd0;
    end

    // Reset only needs to clear valid bits; tag/target contents are don't-care
    // until an entry is written. Reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_en_i) begin
            valid_q[wrIdx]  <= 1'b1;
            tag_q[wrIdx]    <= wr_pc_i[63:JB+2];
            target_q[wrIdx] <= wr_target_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Fetch-stage bimodal predictor (2-bit counters) with a direct-mapped BTB.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   pc_i                 : fetch PC to predict
//   pred_taken_o         : BTB hit and counter predicts taken (combinational)
//   pred_target_o        : BTB target on a hit, else 0
//   upd_valid_i          : resolved-branch update strobe
//   upd_is_b_type_i      : resolved instruction is a conditional branch
//   upd_pc_i             : PC of the resolved branch
//   upd_taken_i          : actual outcome
//   upd_target_i         : actual taken target
//   upd_pred_taken_i     : prediction fetch made for this branch
//   mispredict_o         : registered, one cycle per mispredicting update
//   pred_ghr_o/upd_ghr_i : global history out/in (BP_GSHARE_EN only)
// ---------------------------------------------------------------------------
module branch_predictor
    import cpu_consts::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_i,
    output logic        pred_taken_o,
    output logic [63:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic        upd_is_b_type_i,
    input  logic [63:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [63:0] upd_target_i,
    input  logic        upd_pred_taken_i,
`ifdef BP_GSHARE_EN
    output logic [$clog2(BHT_ENTRIES)-1:0] pred_ghr_o,
    input  logic [$clog2(BHT_ENTRIES)-1:0] upd_ghr_i,
`endif
    output logic        mispredict_o
);

    localparam int IB = $clog2(BHT_ENTRIES);

    bp_ctr_t       ctrTable_q [BHT_ENTRIES];
    bp_ctr_t       rdCtr;
    bp_ctr_t       ctrNext_d;
    logic [IB-1:0] rdIdx;
    logic [IB-1:0] wrIdx;
    logic          updApply;
    logic          mispredict_q;
    logic          btbHit;
    logic [63:0]   btbTarget;

    assign updApply = upd_valid_i & upd_is_b_type_i;

`ifdef BP_GSHARE_EN
    logic [IB-1:0] ghr_q;

    // The update reuses the history fetch saw, not the current one, so the
    // trained counter is the same one that produced the prediction.
    assign rdIdx      = pc_i[IB+1:2] ^ ghr_q;
    assign wrIdx      = upd_pc_i[IB+1:2] ^ upd_ghr_i;
    assign pred_ghr_o = ghr_q;

    // History shifts in each applied outcome; reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (updApply) begin
            ghr_q <= {ghr_q[IB-2:0], upd_taken_i};
        end
    end
`else
    assign rdIdx = pc_i[IB+1:2];
    assign wrIdx = upd_pc_i[IB+1:2];
`endif

    assign rdCtr     = ctrTable_q[rdIdx];
    assign ctrNext_d = bpCtrNext(ctrTable_q[wrIdx], upd_taken_i);

    bp_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .rd_pc_i     (pc_i),
        .rd_hit_o    (btbHit),
        .rd_target_o (btbTarget),
        .wr_en_i     (updApply & upd_taken_i),
        .wr_pc_i     (upd_pc_i),
        .wr_target_i (upd_target_i)
    );

    // Lookup reads the registered table, so a same-cycle update to the same
    // entry is only seen from the next cycle (read-before-write).
    assign pred_taken_o  = btbHit & rdCtr[1];
    assign pred_target_o = btbTarget;
    assign mispredict_o  = mispredict_q;

    // Counter training and the mispredict flag. Reset takes priority and
    // drops any update presented on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctrTable_q[i] <= BP_CTR_RESET;
            end
            mispredict_q <= 1'b0;
        end else begin
            if (updApply) begin
                ctrTable_q[wrIdx] <= ctrNext_d;
            end
            mispredict_q <= updApply & (upd_taken_i ^ upd_pred_taken_i);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Directed self-checking bench for branch_predictor (default bimodal build).
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [63:0] pc_i;
    logic        pred_taken_o;
    logic [63:0] pred_target_o;
    logic        upd_valid_i;
    logic        upd_is_b_type_i;
    logic [63:0] upd_pc_i;
    logic        upd_taken_i;
    logic [63:0] upd_target_i;
    logic        upd_pred_taken_i;
    logic        mispredict_o;

    int compared;
    int mismatched;

    branch_predictor #(
        .BHT_ENTRIES (64),
        .BTB_ENTRIES (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_i             (pc_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .upd_valid_i      (upd_valid_i),
        .upd_is_b_type_i  (upd_is_b_type_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_pred_taken_i (upd_pred_taken_i),
        .mispredict_o     (mispredict_o)
    );

    // 10-time-unit clock; inputs change and outputs are sampled on negedge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts, and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a lookup PC, let it settle, and check both prediction outputs.
    task automatic checkLookup(input string tag, input logic [63:0] pc,
                               input logic expTaken, input logic [63:0] expTarget);
        pc_i = pc;
        #1;
        checkOutput({tag, ".taken"}, {63'd0, pred_taken_o}, {63'd0, expTaken});
        checkOutput({tag, ".target"}, pred_target_o, expTarget);
    endtask

    // Present one update for a single clock edge, then return at the next
    // negedge with the strobe removed.
    task automatic applyStimulus(input logic [63:0] pc, input logic taken,
                                 input logic [63:0] target, input logic predTaken,
                                 input logic isB);
        upd_valid_i      = 1'b1;
        upd_is_b_type_i  = isB;
        upd_pc_i         = pc;
        upd_taken_i      = taken;
        upd_target_i     = target;
        upd_pred_taken_i = predTaken;
        @(posedge clk);
        @(negedge clk);
        upd_valid_i      = 1'b0;
        upd_is_b_type_i  = 1'b0;
    endtask

    initial begin
        compared         = 0;
        mismatched       = 0;
        reset            = 1'b1;
        pc_i             = 64'h1000;
        upd_valid_i      = 1'b0;
        upd_is_b_type_i  = 1'b0;
        upd_pc_i         = 64'd0;
        upd_taken_i      = 1'b0;
        upd_target_i     = 64'd0;
        upd_pred_taken_i = 1'b0;

        // Reset state: no BTB hits, no mispredict.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkLookup("reset_lookup", 64'h1000, 1'b0, 64'd0);
        checkOutput("reset_mispredict", {63'd0, mispredict_o}, 64'd0);

        // First taken update: 01 -> 10, mispredicted (fetch said not-taken).
        applyStimulus(64'h1000, 1'b1, 64'h2000, 1'b0, 1'b1);
        checkOutput("first_upd_mispredict", {63'd0, mispredict_o}, 64'd1);
        checkLookup("first_upd_lookup", 64'h1000, 1'b1, 64'h2000);
        @(negedge clk);
        checkOutput("mispredict_one_cycle", {63'd0, mispredict_o}, 64'd0);

        // Three more taken updates, correctly predicted: saturate at 11.
        applyStimulus(64'h1000, 1'b1, 64'h2000, 1'b1, 1'b1);
        checkOutput("taken2_no_mispredict", {63'd0, mispredict_o}, 64'd0);
        applyStimulus(64'h1000, 1'b1, 64'h2000, 1'b1, 1'b1);
        applyStimulus(64'h1000, 1'b1, 64'h2000, 1'b1, 1'b1);
        checkLookup("saturated_lookup", 64'h1000, 1'b1, 64'h2000);

        // Not-taken from 11 -> 10: still predicts taken, flags mispredict.
        applyStimulus(64'h1000, 1'b0, 64'h0, 1'b1, 1'b1);
        checkOutput("nt1_mispredict", {63'd0, mispredict_o}, 64'd1);
        checkLookup("nt1_lookup", 64'h1000, 1'b1, 64'h2000);

        // Second not-taken 10 -> 01: not taken, BTB entry still present.
        applyStimulus(64'h1000, 1'b0, 64'h0, 1'b1, 1'b1);
        checkLookup("nt2_lookup", 64'h1000, 1'b0, 64'h2000);

        // Train taken again (01 -> 10), then probe aliasing PCs.
        applyStimulus(64'h1000, 1'b1, 64'h2000, 1'b0, 1'b1);
        checkLookup("retrain_lookup", 64'h1000, 1'b1, 64'h2000);
        checkLookup("alias_btb_idx", 64'h1040, 1'b0, 64'd0);
        checkLookup("alias_btb_and_bht_idx", 64'h1100, 1'b0, 64'd0);

        // Back to 01, then same-cycle lookup + taken update of 0x1000.
        applyStimulus(64'h1000, 1'b0, 64'h0, 1'b1, 1'b1);
        pc_i             = 64'h1000;
        upd_valid_i      = 1'b1;
        upd_is_b_type_i  = 1'b1;
        upd_pc_i         = 64'h1000;
        upd_taken_i      = 1'b1;
        upd_target_i     = 64'h2000;
        upd_pred_taken_i = 1'b0;
        #1;
        checkOutput("same_cycle_pre", {63'd0, pred_taken_o}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        upd_valid_i      = 1'b0;
        upd_is_b_type_i  = 1'b0;
        checkLookup("same_cycle_post", 64'h1000, 1'b1, 64'h2000);

        // Non-B-type updates (counter is 10): must change nothing.
        applyStimulus(64'h1000, 1'b1, 64'h3000, 1'b0, 1'b0);
        checkOutput("nonb_mispredict", {63'd0, mispredict_o}, 64'd0);
        checkLookup("nonb_taken_lookup", 64'h1000, 1'b1, 64'h2000);
        applyStimulus(64'h1000, 1'b0, 64'h0, 1'b1, 1'b0);
        checkLookup("nonb_nt_lookup", 64'h1000, 1'b1, 64'h2000);
        applyStimulus(64'h2000, 1'b1, 64'h4000, 1'b0, 1'b0);
        checkLookup("nonb_no_btb_write", 64'h2000, 1'b0, 64'd0);

        // Update on the same edge as reset is dropped.
        reset            = 1'b1;
        applyStimulus(64'h1000, 1'b1, 64'h2000, 1'b0, 1'b1);
        reset            = 1'b0;
        checkLookup("reset_drop_lookup", 64'h1000, 1'b0, 64'd0);
        checkOutput("reset_drop_mispredict", {63'd0, mispredict_o}, 64'd0);
        // Counter must be 01: one taken -> taken, one not-taken -> not-taken.
        applyStimulus(64'h1000, 1'b1, 64'h2000, 1'b0, 1'b1);
        checkLookup("post_reset_t", 64'h1000, 1'b1, 64'h2000);
        applyStimulus(64'h1000, 1'b0, 64'h0, 1'b1, 1'b1);
        checkLookup("post_reset_nt", 64'h1000, 1'b0, 64'h2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
